// File: rtl/matrix_result_reader_if.sv
// Memory read port plus downstream element stream used by matrix_result_reader.
// The reader is the master: it drives the address/control and the stream data.
interface matrix_result_reader_if;
  logic [1:0] matrix_select;
  logic [1:0] row;
  logic [1:0] col;
  logic       write_enable;
  logic [7:0] write_data;
  logic [7:0] read_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output matrix_select, row, col, write_enable, write_data, out_data, out_valid,
    input  read_data, out_ready
  );

  modport slave (
    input  matrix_select, row, col, write_enable, write_data, out_data, out_valid,
    output read_data, out_ready
  );
endinterface

// File: rtl/matrix_result_reader.sv
// Drains the 4x4 result matrix from Memory row-major and streams each element
// over a valid/ready handshake; busy requests the Memory port mux.
module matrix_result_reader #(
  parameter logic [1:0] RESULT_SEL = 2'd2,
  parameter int         RD_LAT     = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic finished,
  matrix_result_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;

  state_t     state, state_nxt;
  logic [3:0] idx, idx_nxt;
  logic [7:0] data_q, data_nxt;
  logic       vld_q, vld_nxt;
  logic       busy_nxt, fin_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= 4'd0;
      data_q   <= 8'h00;
      vld_q    <= 1'b0;
      busy     <= 1'b0;
      finished <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      data_q   <= data_nxt;
      vld_q    <= vld_nxt;
      busy     <= busy_nxt;
      finished <= fin_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    data_nxt  = data_q;
    vld_nxt   = vld_q;
    busy_nxt  = busy;
    fin_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          idx_nxt   = 4'd0;
          busy_nxt  = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        // With a registered read the address must sit one extra cycle first
        if (RD_LAT == 0) begin
          data_nxt  = bus.read_data;
          vld_nxt   = 1'b1;
          state_nxt = HOLD;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        data_nxt  = bus.read_data;
        vld_nxt   = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          vld_nxt = 1'b0;
          if (idx == 4'd15) begin
            busy_nxt  = 1'b0;
            fin_nxt   = 1'b1;
            idx_nxt   = 4'd0;
            state_nxt = IDLE;
          end else begin
            idx_nxt   = idx + 4'd1;
            state_nxt = FETCH;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.matrix_select = RESULT_SEL;
  assign bus.row           = idx[3:2];
  assign bus.col           = idx[1:0];
  assign bus.write_enable  = 1'b0;
  assign bus.write_data    = 8'h00;
  assign bus.out_data      = data_q;
  assign bus.out_valid     = vld_q;

endmodule

// File: tb/tb_matrix_result_reader.sv
// Bench for matrix_result_reader: combinational-read and registered-read instances
// against a preloaded result matrix, scoreboarded stream plus a latency table.
module tb_matrix_result_reader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic ready0 = 1'b1, ready1 = 1'b1;
  logic busy0, fin0, busy1, fin1;
  logic [7:0] mem [16];
  logic [7:0] rd1 = 8'h00;
  int cyc = 0;
  int total = 0, bad = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int last1 = 0, k1 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matrix_result_reader_if b0();
  matrix_result_reader_if b1();

  matrix_result_reader #(.RESULT_SEL(2'd2), .RD_LAT(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .busy(busy0), .finished(fin0), .bus(b0));
  matrix_result_reader #(.RESULT_SEL(2'd2), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .finished(fin1), .bus(b1));

  // Memory models: combinational read for dut0, one-cycle registered read for dut1
  assign b0.read_data = mem[{b0.row, b0.col}];
  always @(posedge clk) rd1 <= mem[{b1.row, b1.col}];
  assign b1.read_data = rd1;
  assign b0.out_ready = ready0;
  assign b1.out_ready = ready1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push0();
    for (int i = 0; i < 16; i++) q0.push_back(8'h10 + 8'(i));
  endtask

  task automatic wait_beat0(input logic [7:0] d);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(b0.out_valid && b0.out_data == d) && n < 200);
    check("wait_beat", 32'(n < 200), 32'd1);
  endtask

  task automatic wait_fin0();
    int n = 0;
    do begin @(negedge clk); n++; end while (!fin0 && n < 200);
    check("wait_finished", 32'(n < 200), 32'd1);
  endtask

  // Scoreboards: every accepted beat must be the next expected element
  always @(negedge clk) begin
    if (!reset && b0.out_valid && b0.out_ready) begin
      if (q0.size() == 0) check("extra_beat0", 32'(b0.out_data), 32'hFFFF);
      else check("beat0", 32'(b0.out_data), 32'(q0.pop_front()));
      check("write_enable0", 32'(b0.write_enable), 32'd0);
      check("matrix_select0", 32'(b0.matrix_select), 32'd2);
    end
    if (!reset && b1.out_valid && b1.out_ready) begin
      if (q1.size() == 0) check("extra_beat1", 32'(b1.out_data), 32'hFFFF);
      else check("beat1", 32'(b1.out_data), 32'(q1.pop_front()));
      if (k1 > 0) check("lat1_gap", 32'(cyc - last1), 32'd3);
      last1 = cyc;
      k1++;
    end
    if (b0.write_enable !== 1'b0 || b1.write_enable !== 1'b0)
      check("write_enable_any", 32'(b0.write_enable | b1.write_enable), 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         e;
    logic       v;
    logic [7:0] d;
    logic [3:0] ix;
    logic       b;
    logic       f;
  } vec_t;
  vec_t tab [10];

  initial begin
    int t0, n;
    tab[0] = '{1,  1'b0, 8'h00, 4'd0,  1'b1, 1'b0};
    tab[1] = '{2,  1'b1, 8'h10, 4'd0,  1'b1, 1'b0};
    tab[2] = '{3,  1'b0, 8'h10, 4'd1,  1'b1, 1'b0};
    tab[3] = '{4,  1'b1, 8'h11, 4'd1,  1'b1, 1'b0};
    tab[4] = '{9,  1'b0, 8'h13, 4'd4,  1'b1, 1'b0};
    tab[5] = '{10, 1'b1, 8'h14, 4'd4,  1'b1, 1'b0};
    tab[6] = '{32, 1'b1, 8'h1F, 4'd15, 1'b1, 1'b0};
    tab[7] = '{33, 1'b0, 8'h1F, 4'd0,  1'b0, 1'b1};
    tab[8] = '{34, 1'b0, 8'h1F, 4'd0,  1'b0, 1'b0};
    tab[9] = '{40, 1'b0, 8'h1F, 4'd0,  1'b0, 1'b0};
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);

    // Reset values and constant outputs while reset is held
    #12;
    check("rst_valid", 32'(b0.out_valid), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_fin", 32'(fin0), 32'd0);
    check("rst_addr", 32'({b0.row, b0.col}), 32'd0);
    check("rst_data", 32'(b0.out_data), 32'd0);
    check("rst_sel", 32'(b0.matrix_select), 32'd2);
    check("rst_we", 32'(b0.write_enable), 32'd0);
    @(negedge clk) reset = 1'b0;

    // Ready high in IDLE without start does nothing
    repeat (5) begin
      @(negedge clk);
      check("idle_valid", 32'(b0.out_valid), 32'd0);
      check("idle_busy", 32'(busy0), 32'd0);
      check("idle_addr", 32'({b0.row, b0.col}), 32'd0);
    end

    // Latency table: start driven just after edge 0
    @(posedge clk); #1 start0 = 1'b1; push0(); t0 = cyc;
    fork begin @(posedge clk); #1 start0 = 1'b0; end join_none
    for (int i = 0; i < 10; i++) begin
      while (cyc != t0 + tab[i].e) @(negedge clk);
      check($sformatf("tab%0d_valid", tab[i].e), 32'(b0.out_valid), 32'(tab[i].v));
      check($sformatf("tab%0d_data", tab[i].e), 32'(b0.out_data), 32'(tab[i].d));
      check($sformatf("tab%0d_idx", tab[i].e), 32'({b0.row, b0.col}), 32'(tab[i].ix));
      check($sformatf("tab%0d_busy", tab[i].e), 32'(busy0), 32'(tab[i].b));
      check($sformatf("tab%0d_fin", tab[i].e), 32'(fin0), 32'(tab[i].f));
    end

    // Backpressure on beat 3: element must be held, not dropped
    @(posedge clk); #1 start0 = 1'b1; push0();
    @(posedge clk); #1 start0 = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(busy0 && !b0.out_valid && {b0.row, b0.col} == 4'd3) && n < 200);
    check("stall_reach", 32'(n < 200), 32'd1);
    @(posedge clk); #1 ready0 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", 32'(b0.out_valid), 32'd1);
      check("stall_data", 32'(b0.out_data), 32'h13);
      check("stall_addr", 32'({b0.row, b0.col}), 32'd3);
    end
    @(posedge clk); #1 ready0 = 1'b1;
    wait_fin0();

    // Start mid-drain ignored; start in the finished cycle begins a new drain
    @(posedge clk); #1 start0 = 1'b1; push0();
    @(posedge clk); #1 start0 = 1'b0;
    wait_beat0(8'h17);
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    wait_fin0();
    start0 = 1'b1; push0();
    @(posedge clk); #1 start0 = 1'b0;
    @(negedge clk);
    check("restart_busy", 32'(busy0), 32'd1);
    wait_fin0();

    // Asynchronous reset during beat 9
    @(posedge clk); #1 start0 = 1'b1; push0();
    @(posedge clk); #1 start0 = 1'b0;
    wait_beat0(8'h19);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 32'(b0.out_valid), 32'd0);
    check("arst_busy", 32'(busy0), 32'd0);
    check("arst_addr", 32'({b0.row, b0.col}), 32'd0);
    q0.delete();
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1 start0 = 1'b1; push0();
    @(posedge clk); #1 start0 = 1'b0;
    wait_beat0(8'h10);
    wait_fin0();

    // Registered-read instance: same stream, one beat per 3 cycles
    k1 = 0;
    @(posedge clk); #1 start1 = 1'b1;
    for (int i = 0; i < 16; i++) q1.push_back(8'h10 + 8'(i));
    @(posedge clk); #1 start1 = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!fin1 && n < 200);
    check("lat1_finished", 32'(n < 200), 32'd1);
    check("lat1_beats", 32'(k1), 32'd16);

    check("q0_empty", 32'(q0.size()), 32'd0);
    check("q1_empty", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
